// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the round-robin MEM arbiter and its ID FIFO.
package mem_arb_pkg;

   typedef enum logic {ARB, HOLD} arb_state_e;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO holding the requester index of each outstanding MEM transaction.
module mem_arb_id_fifo
   import mem_arb_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = idx_width(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // DEPTH is a power of two, so the pointers wrap without explicit compare.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one MEM slave port among NUM_REQ requesters.
// Define MEM_RR_ARBITER_PERF_EN to add per-requester grant counters (grant_cnt_o).
module mem_rr_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ         = 4,
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [NUM_REQ-1:0]               s_mem_req_i,
   output logic [NUM_REQ-1:0]               s_mem_gnt_o,
   output logic [NUM_REQ-1:0]               s_mem_valid_o,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    s_mem_addr_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    s_mem_wdata_i,
   input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  s_mem_be_i,
   input  logic [NUM_REQ-1:0]               s_mem_we_i,
   output logic [NUM_REQ*DATA_WIDTH-1:0]    s_mem_rdata_o,
   output logic [NUM_REQ-1:0]               s_mem_error_o,
   output logic                             m_mem_req_o,
   input  logic                             m_mem_gnt_i,
   input  logic                             m_mem_valid_i,
   output logic [ADDR_WIDTH-1:0]            m_mem_addr_o,
   output logic [DATA_WIDTH-1:0]            m_mem_wdata_o,
   output logic [DATA_WIDTH/8-1:0]          m_mem_be_o,
   output logic                             m_mem_we_o,
   input  logic [DATA_WIDTH-1:0]            m_mem_rdata_i,
   input  logic                             m_mem_error_i,
   output logic                             proto_err_o
`ifdef MEM_RR_ARBITER_PERF_EN
   ,
   output logic [NUM_REQ*32-1:0]            grant_cnt_o
`endif
);

   localparam int IDX_W = idx_width(NUM_REQ);
   localparam int BE_W  = DATA_WIDTH / 8;

   arb_state_e       state;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] hold_idx;
   logic [IDX_W-1:0] arb_idx;
   logic [IDX_W-1:0] cand;
   logic [IDX_W-1:0] sel_idx;
   logic [IDX_W-1:0] nxt_ptr;
   logic [IDX_W-1:0] head_idx;
   logic             arb_found;
   logic             fifo_full;
   logic             fifo_empty;
   logic             hs;
   logic             pop;

   // Search from rr_ptr upward; the subtraction handles wrap for any NUM_REQ.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (int'(rr_ptr) >= NUM_REQ - i) cand = rr_ptr - IDX_W'(NUM_REQ - i);
         else                             cand = rr_ptr + IDX_W'(i);
         if (!arb_found && s_mem_req_i[cand]) begin
            arb_found = 1'b1;
            arb_idx   = cand;
         end
      end
   end

   always_comb begin
      sel_idx     = (state == HOLD) ? hold_idx : arb_idx;
      m_mem_req_o = (state == HOLD) ? s_mem_req_i[hold_idx] : (arb_found & ~fifo_full);
      hs          = m_mem_req_o & m_mem_gnt_i;
      nxt_ptr     = (int'(sel_idx) == NUM_REQ - 1) ? '0 : sel_idx + 1'b1;

      s_mem_gnt_o          = '0;
      s_mem_gnt_o[sel_idx] = hs;

      m_mem_addr_o  = '0;
      m_mem_wdata_o = '0;
      m_mem_be_o    = '0;
      m_mem_we_o    = 1'b0;
      if (m_mem_req_o) begin
         m_mem_addr_o  = s_mem_addr_i[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
         m_mem_wdata_o = s_mem_wdata_i[sel_idx*DATA_WIDTH +: DATA_WIDTH];
         m_mem_be_o    = s_mem_be_i[sel_idx*BE_W +: BE_W];
         m_mem_we_o    = s_mem_we_i[sel_idx];
      end
   end

   assign pop = m_mem_valid_i & ~fifo_empty;

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_rsp
      assign s_mem_valid_o[k] = pop & (head_idx == IDX_W'(k));
      assign s_mem_rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = s_mem_valid_o[k] ? m_mem_rdata_i : '0;
      assign s_mem_error_o[k] = s_mem_valid_o[k] & m_mem_error_i;
   end

   // HOLD pins the selection so the payload stays stable until the grant arrives.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= ARB;
         rr_ptr      <= '0;
         hold_idx    <= '0;
         proto_err_o <= 1'b0;
      end else begin
         if (m_mem_valid_i && fifo_empty) proto_err_o <= 1'b1;
         if (hs) rr_ptr <= nxt_ptr;
         unique case (state)
            ARB: begin
               if (m_mem_req_o && !m_mem_gnt_i) begin
                  hold_idx <= arb_idx;
                  state    <= HOLD;
               end
            end
            HOLD: begin
               if (!s_mem_req_i[hold_idx] || m_mem_gnt_i) state <= ARB;
            end
         endcase
      end
   end

   mem_arb_id_fifo #(
      .WIDTH (IDX_W),
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (hs),
      .pop   (pop),
      .din   (sel_idx),
      .dout  (head_idx),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

`ifdef MEM_RR_ARBITER_PERF_EN
   for (genvar k = 0; k < NUM_REQ; k++) begin : g_perf
      logic [31:0] cnt;
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) cnt <= '0;
         else if (hs && (sel_idx == IDX_W'(k)) && (cnt != '1)) cnt <= cnt + 1'b1;
      end
      assign grant_cnt_o[k*32 +: 32] = cnt;
   end
`endif

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Scoreboard bench for mem_rr_arbiter (4 requesters, 32-bit data/address).
module tb_mem_rr_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int AW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    s_mem_req_i;
   logic [N-1:0]    s_mem_gnt_o;
   logic [N-1:0]    s_mem_valid_o;
   logic [N*AW-1:0] s_mem_addr_i;
   logic [N*DW-1:0] s_mem_wdata_i;
   logic [N*DW/8-1:0] s_mem_be_i;
   logic [N-1:0]    s_mem_we_i;
   logic [N*DW-1:0] s_mem_rdata_o;
   logic [N-1:0]    s_mem_error_o;
   logic            m_mem_req_o;
   logic            m_mem_gnt_i;
   logic            m_mem_valid_i;
   logic [AW-1:0]   m_mem_addr_o;
   logic [DW-1:0]   m_mem_wdata_o;
   logic [DW/8-1:0] m_mem_be_o;
   logic            m_mem_we_o;
   logic [DW-1:0]   m_mem_rdata_i;
   logic            m_mem_error_i;
   logic            proto_err_o;
`ifdef MEM_RR_ARBITER_PERF_EN
   logic [N*32-1:0] grant_cnt_o;
`endif

   int          total = 0;
   int          bad   = 0;
   int          sb_q[$];
   logic [31:0] mem_q[$];

   mem_rr_arbiter #(
      .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(4)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .s_mem_req_i   (s_mem_req_i),
      .s_mem_gnt_o   (s_mem_gnt_o),
      .s_mem_valid_o (s_mem_valid_o),
      .s_mem_addr_i  (s_mem_addr_i),
      .s_mem_wdata_i (s_mem_wdata_i),
      .s_mem_be_i    (s_mem_be_i),
      .s_mem_we_i    (s_mem_we_i),
      .s_mem_rdata_o (s_mem_rdata_o),
      .s_mem_error_o (s_mem_error_o),
      .m_mem_req_o   (m_mem_req_o),
      .m_mem_gnt_i   (m_mem_gnt_i),
      .m_mem_valid_i (m_mem_valid_i),
      .m_mem_addr_o  (m_mem_addr_o),
      .m_mem_wdata_o (m_mem_wdata_o),
      .m_mem_be_o    (m_mem_be_o),
      .m_mem_we_o    (m_mem_we_o),
      .m_mem_rdata_i (m_mem_rdata_i),
      .m_mem_error_i (m_mem_error_i),
      .proto_err_o   (proto_err_o)
`ifdef MEM_RR_ARBITER_PERF_EN
      ,
      .grant_cnt_o   (grant_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] addr_of(input int k);
      return 32'h1000_0000 + 32'(4 * k);
   endfunction

   // Drive one cycle's inputs just after a rising edge, then wait to sample at the falling edge.
   task automatic drive(input logic [N-1:0] req, input logic gnt, input bit rsp);
      s_mem_req_i   = req;
      m_mem_gnt_i   = gnt;
      m_mem_valid_i = rsp;
      m_mem_rdata_i = '0;
      m_mem_error_i = 1'b0;
      if (rsp) begin
         if (mem_q.size() > 0) m_mem_rdata_i = mem_q.pop_front();
         else                  m_mem_rdata_i = 32'hDEAD_BEEF;
         m_mem_error_i = (m_mem_rdata_i == 32'hA3);
      end
      @(negedge clk);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_grant(input string tag, input int k);
      check({tag, "_req"},   m_mem_req_o, 1);
      check({tag, "_gnt"},   s_mem_gnt_o, 128'(1 << k));
      check({tag, "_addr"},  m_mem_addr_o, addr_of(k));
      check({tag, "_wdata"}, m_mem_wdata_o, 32'hD0 + 32'(k));
      check({tag, "_we"},    m_mem_we_o, 128'(k % 2));
      sb_q.push_back(k);
      mem_q.push_back(32'hA0 + {29'b0, m_mem_addr_o[4:2]});
   endtask

   task automatic expect_rsp(input string tag);
      int k;
      logic [127:0] exp_rd;
      check({tag, "_sb_nonempty"}, (sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
         k = sb_q.pop_front();
         exp_rd = 128'(32'hA0 + 32'(k)) << (32 * k);
         check({tag, "_valid"}, s_mem_valid_o, 128'(1 << k));
         check({tag, "_rdata"}, s_mem_rdata_o, exp_rd);
         check({tag, "_error"}, s_mem_error_o, (k == 3) ? 128'h8 : 128'h0);
      end
   endtask

   initial begin
      rst           = 1'b1;
      s_mem_req_i   = '0;
      m_mem_gnt_i   = 1'b0;
      m_mem_valid_i = 1'b0;
      m_mem_rdata_i = '0;
      m_mem_error_i = 1'b0;
      s_mem_be_i    = '1;
      for (int k = 0; k < N; k++) begin
         s_mem_addr_i[k*AW +: AW]  = addr_of(k);
         s_mem_wdata_i[k*DW +: DW] = 32'hD0 + 32'(k);
         s_mem_we_i[k]             = (k % 2 == 1);
      end
      repeat (2) @(posedge clk);
      #1;
      check("rst_req",   m_mem_req_o, 0);
      check("rst_gnt",   s_mem_gnt_o, 0);
      check("rst_valid", s_mem_valid_o, 0);
      check("rst_proto", proto_err_o, 0);
      rst = 1'b0;

      // All requesters active, responses one cycle after each grant
      drive(4'hF, 1'b1, 1'b0);
      expect_grant("t1_g0", 0);
      next_cycle();
      for (int i = 1; i <= 4; i++) begin
         drive(4'hF, 1'b1, 1'b1);
         expect_rsp($sformatf("t1_r%0d", i));
         expect_grant($sformatf("t1_g%0d", i), i % 4);
         next_cycle();
      end
      drive(4'h0, 1'b0, 1'b1);
      expect_rsp("t1_rlast");
      check("t1_idle_req", m_mem_req_o, 0);
      next_cycle();
      check("t1_proto", proto_err_o, 0);

      // Grant stall on requester 2 while requester 0 joins
      drive(4'b0100, 1'b0, 1'b0);
      check("t2_req",  m_mem_req_o, 1);
      check("t2_addr", m_mem_addr_o, 32'h1000_0008);
      check("t2_gnt",  s_mem_gnt_o, 0);
      next_cycle();
      for (int i = 1; i <= 2; i++) begin
         drive(4'b0101, 1'b0, 1'b0);
         check($sformatf("t2_hold_addr%0d", i), m_mem_addr_o, 32'h1000_0008);
         check($sformatf("t2_hold_gnt%0d", i), s_mem_gnt_o, 0);
         next_cycle();
      end
      drive(4'b0101, 1'b1, 1'b0);
      expect_grant("t2_g2", 2);
      next_cycle();
      drive(4'b0001, 1'b1, 1'b1);
      expect_rsp("t2_r2");
      expect_grant("t2_g0", 0);
      next_cycle();
      drive(4'h0, 1'b0, 1'b1);
      expect_rsp("t2_r0");
      next_cycle();

      // Fill the ID FIFO, then free one slot
      for (int i = 0; i < 4; i++) begin
         drive(4'hF, 1'b1, 1'b0);
         expect_grant($sformatf("t3_g%0d", i), (1 + i) % 4);
         next_cycle();
      end
      drive(4'hF, 1'b1, 1'b0);
      check("t3_full_req", m_mem_req_o, 0);
      check("t3_full_gnt", s_mem_gnt_o, 0);
      next_cycle();
      drive(4'hF, 1'b1, 1'b1);
      check("t3_pop_req", m_mem_req_o, 0);
      check("t3_pop_gnt", s_mem_gnt_o, 0);
      expect_rsp("t3_rpop");
      next_cycle();
      drive(4'hF, 1'b1, 1'b0);
      expect_grant("t3_after", 1);
      next_cycle();
      for (int i = 0; i < 4; i++) begin
         drive(4'h0, 1'b0, 1'b1);
         expect_rsp($sformatf("t3_drain%0d", i));
         next_cycle();
      end

      // Response with nothing outstanding
      drive(4'h0, 1'b0, 1'b1);
      check("t4_valid", s_mem_valid_o, 0);
      check("t4_proto_pre", proto_err_o, 0);
      next_cycle();
      drive(4'h0, 1'b0, 1'b0);
      check("t4_proto_set", proto_err_o, 1);
      next_cycle();
      repeat (3) begin
         drive(4'h0, 1'b0, 1'b0);
         next_cycle();
      end
      check("t4_proto_sticky", proto_err_o, 1);

      // Asynchronous reset with two transactions outstanding
      drive(4'hF, 1'b1, 1'b0);
      expect_grant("t5_g2", 2);
      next_cycle();
      drive(4'hF, 1'b1, 1'b0);
      expect_grant("t5_g3", 3);
      next_cycle();
      #2;
      s_mem_req_i   = '0;
      m_mem_gnt_i   = 1'b0;
      m_mem_valid_i = 1'b0;
      rst           = 1'b1;
      #1;
      check("t5_rst_req",   m_mem_req_o, 0);
      check("t5_rst_gnt",   s_mem_gnt_o, 0);
      check("t5_rst_valid", s_mem_valid_o, 0);
      check("t5_rst_proto", proto_err_o, 0);
      sb_q.delete();
      mem_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(4'hF, 1'b1, 1'b0);
      expect_grant("t5_first", 0);
      next_cycle();
      drive(4'h0, 1'b0, 1'b1);
      expect_rsp("t5_r0");
      next_cycle();
      drive(4'h0, 1'b0, 1'b1);
      check("t5_stray_valid", s_mem_valid_o, 0);
      next_cycle();
      check("t5_stray_proto", proto_err_o, 1);

`ifdef MEM_RR_ARBITER_PERF_EN
      // Grant counters
      #2;
      s_mem_req_i   = '0;
      m_mem_gnt_i   = 1'b0;
      m_mem_valid_i = 1'b0;
      rst           = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("t6_cnt_rst", grant_cnt_o, 0);
      for (int i = 0; i < 5; i++) begin
         drive(4'b0010, 1'b1, (i > 0));
         if (i > 0) expect_rsp($sformatf("t6_r%0d", i));
         expect_grant($sformatf("t6_g%0d", i), 1);
         next_cycle();
      end
      drive(4'h0, 1'b0, 1'b1);
      expect_rsp("t6_rlast");
      next_cycle();
      check("t6_cnt", grant_cnt_o, 128'h0000_0000_0000_0000_0000_0005_0000_0000);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Round-robin arbiter that shares one MEM-protocol slave port (for example, the MEM port of a custom unit wrapper) between NUM_REQ MEM-protocol requesters.
- Tracks outstanding transactions in an in-order ID FIFO and routes each response back to the requester that issued it.
- Sits between requester masters and the custom unit's MEM interface, inside the custom-unit hierarchy.

Parameters:
NUM_REQ, 4, number of requesters; 2..8
DATA_WIDTH, 32, MEM data width
ADDR_WIDTH, 32, MEM address width
MAX_OUTSTANDING, 4, ID FIFO depth; power of 2, at least 2

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
s_mem_req_i  in  NUM_REQ  per-requester request
s_mem_gnt_o  out  NUM_REQ  per-requester grant
s_mem_valid_o  out  NUM_REQ  per-requester response valid
s_mem_addr_i  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester k occupies slice k
s_mem_wdata_i  in  NUM_REQ*DATA_WIDTH  flattened write data
s_mem_be_i  in  NUM_REQ*DATA_WIDTH/8  flattened byte enables
s_mem_we_i  in  NUM_REQ  write enable
s_mem_rdata_o  out  NUM_REQ*DATA_WIDTH  flattened read data
s_mem_error_o  out  NUM_REQ  response error
m_mem_req_o  out  1  shared request
m_mem_gnt_i  in  1  shared grant
m_mem_valid_i  in  1  shared response valid
m_mem_addr_o / m_mem_wdata_o / m_mem_be_o / m_mem_we_o  out  ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8 / 1  muxed request payload
m_mem_rdata_i  in  DATA_WIDTH  response data
m_mem_error_i  in  1  response error
proto_err_o  out  1  sticky: m_mem_valid_i received with no outstanding transaction

Behaviour:
- Clocking and reset: single clock clk_i; rst_i asynchronous, active-high.
- Reset values: FIFO empty, rr_ptr=0, state=ARB, proto_err_o=0. All outputs are combinational from state, so with no inputs active every output is 0.
- A handshake is req & gnt in the same cycle. Responses arrive in order, at least 1 cycle after their grant.
- State ARB:
  - If FIFO not full: winner = first asserted s_mem_req_i[k], searching from rr_ptr upward with wrap.
  - m_mem_req_o=1; payload driven from the winner's slice.
  - If FIFO full: m_mem_req_o=0 and no s_mem_gnt_o asserted.
- Grant routing: s_mem_gnt_o[winner] = m_mem_gnt_i; every other gnt bit is 0. Zero-cycle grant path.
- On handshake:
  - Push winner index into the FIFO.
  - rr_ptr <= (winner+1) mod NUM_REQ.
  - Stay in ARB.
- Request issued but m_mem_gnt_i=0: latch winner into hold_idx and go to HOLD.
- State HOLD:
  - Selection is forced to hold_idx; no re-arbitration, so address and payload stay stable until grant.
  - m_mem_req_o = s_mem_req_i[hold_idx]. If the requester drops its request, return to ARB next cycle without pushing.
  - On handshake: push, update rr_ptr, return to ARB.
  - The full check is not applied in HOLD: HOLD is only entered when the FIFO is not full, and only one entry can be pushed per cycle.
- Response routing:
  - m_mem_valid_i with FIFO non-empty: s_mem_valid_o[head]=1; rdata and error are broadcast to all slices, qualified by valid; pop.
  - m_mem_valid_i with FIFO empty: all s_mem_valid_o stay 0, proto_err_o <= 1 and stays set until reset.
- Simultaneous push and pop in one cycle: allowed; count is unchanged.
- Full boundary: FIFO full and pop in the same cycle still blocks the new request that cycle (full is computed from registered count). The request is granted the next cycle.
- Wrap-around: FIFO pointers are log2(MAX_OUTSTANDING) bits; count is log2+1 bits; pointers wrap naturally.
- Reset mid-operation: outstanding entries are discarded. Responses arriving after reset set proto_err_o.

Optional Feature:
- Macro: MEM_RR_ARBITER_PERF_EN.
- Defined: adds output grant_cnt_o, NUM_REQ*32 bits, one counter per requester. Each counter increments on that requester's handshake, saturates at 0xFFFFFFFF, and resets to 0.
- Undefined: no counters and no grant_cnt_o port.

Decomposition:
- Package mem_arb_pkg:
  - localparam-style function idx_width(n) = $clog2(n), with a minimum of 1.
  - typedef enum logic {ARB, HOLD} arb_state_e.
- Sub-module mem_arb_id_fifo:
  - Parameterised width/depth synchronous FIFO.
  - push, pop, din, dout, full, empty ports; asynchronous active-high reset.

Test Plan:
1. All 4 requesters hold req; m_mem_gnt_i=1 and valid returned 1 cycle after each grant -> grants in order 0,1,2,3,0; each requester's rdata (0xA0+k) lands only on s_mem_valid_o[k].
2. Requester 2 alone requests; m_mem_gnt_i=0 for 3 cycles, and requester 0 raises req in cycle 1 -> addr stays at requester 2's value 0x1000_0008, no switch; grant goes to 2 in cycle 3; next grant goes to 0.
3. Continuous grants with responses withheld -> after 4 handshakes m_mem_req_o=0 and no gnt bit is set. Then one valid -> one pop; the next request is granted the cycle after.
4. Pulse m_mem_valid_i with the FIFO empty -> no s_mem_valid_o bit asserted; proto_err_o=1 and held until rst_i.
5. Assert rst_i asynchronously with 2 transactions outstanding -> all outputs 0 immediately; rr_ptr=0; the first grant after reset goes to requester 0.
6. Build with MEM_RR_ARBITER_PERF_EN; requester 1 performs 5 handshakes -> grant_cnt_o slice 1 = 5, all other slices 0.
